// File: rtl/dsm_output_sequencer.sv
// dsm_output_sequencer
// Run/mute sequencer between the 1-bit delta-sigma quantizer and the DSD
// output stage. While not running it sends the DSD idle byte MSB first. It
// switches to live quantizer bits only after a number of whole idle bytes.
// It also latches a fault, which forces mute, when the live stream sticks
// at one value for too long.
// All run/mute changes land on byte boundaries (PHASE==7), except the fault
// cut-over, which takes effect on the very next bit.
module dsm_output_sequencer #(
    parameter int         ARM_BYTES      = 16,     // 1..255
    parameter int         MAX_RUN_LENGTH = 28,     // 2..63
    parameter logic [7:0] MUTE_PATTERN   = 8'h69
) (
    input  logic       BCLK_I,
    input  logic       RESET_I,
    input  logic       ENABLE_I,
    input  logic       CLEAR_FAULT_I,
    input  logic       QUANT_DATA_I,
    output logic       DSD_DATA_O,
    output logic       MUTED_O,
    output logic       RUNNING_O,
    output logic       FAULT_O,
    output logic [2:0] STATE_O
);

    localparam logic [7:0] LP_ARM_LAST = 8'(ARM_BYTES - 1);
    localparam logic [5:0] LP_MAX_RUN  = 6'(MAX_RUN_LENGTH);

    typedef enum logic [2:0] {
        ST_MUTE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_FAULT = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_phase;
    logic       w_boundary;
    logic [7:0] r_byte_cnt;
    logic [7:0] w_byte_cnt_next;
    logic [5:0] r_run_cnt;
    logic [5:0] w_run_cnt_next;
    logic [5:0] w_run_cnt_inc;
    logic [5:0] w_run_cnt_live;
    logic       r_prev_bit;
    logic       w_run_fault;
    logic       r_dsd;
    logic       r_muted;

    assign w_boundary = (r_phase == 3'd7);

    // Bit position within the current byte; free-running in every state.
    always_ff @(posedge BCLK_I or posedge RESET_I) begin
        if (RESET_I) begin
            r_phase <= 3'd0;
        end else begin
            r_phase <= r_phase + 3'd1;
        end
    end

    // Length of the current run of identical live bits, including this one.
    // On the RUN entry edge r_prev_bit captures that edge's quantizer bit,
    // which serves as the reference for the first live bit.
    always_comb begin
        w_run_cnt_inc  = (r_run_cnt == 6'd63) ? r_run_cnt : r_run_cnt + 6'd1;
        w_run_cnt_live = (QUANT_DATA_I == r_prev_bit) ? w_run_cnt_inc : 6'd1;
        w_run_fault    = (r_state == ST_RUN) && (w_run_cnt_live == LP_MAX_RUN);
    end

    // Next-state, arm byte counter and run counter; fault beats disable.
    always_comb begin
        w_state_next    = r_state;
        w_byte_cnt_next = r_byte_cnt;
        w_run_cnt_next  = 6'd0;
        case (r_state)
            ST_MUTE: begin
                if (w_boundary && ENABLE_I) begin
                    w_state_next    = ST_ARM;
                    w_byte_cnt_next = 8'd0;
                end
            end
            ST_ARM: begin
                if (w_boundary) begin
                    if (!ENABLE_I) begin
                        w_state_next = ST_MUTE;
                    end else if (r_byte_cnt == LP_ARM_LAST) begin
                        w_state_next   = ST_RUN;
                        w_run_cnt_next = 6'd1;
                    end else begin
                        w_byte_cnt_next = r_byte_cnt + 8'd1;
                    end
                end
            end
            ST_RUN: begin
                if (w_run_fault) begin
                    w_state_next = ST_FAULT;
                end else if (w_boundary && !ENABLE_I) begin
                    w_state_next = ST_MUTE;
                end else begin
                    w_run_cnt_next = w_run_cnt_live;
                end
            end
            ST_FAULT: begin
                if (w_boundary && CLEAR_FAULT_I && !ENABLE_I) begin
                    w_state_next = ST_MUTE;
                end
            end
            default: begin
                w_state_next = ST_MUTE;
            end
        endcase
    end

    // State, counters and previous-bit register.
    always_ff @(posedge BCLK_I or posedge RESET_I) begin
        if (RESET_I) begin
            r_state    <= ST_MUTE;
            r_byte_cnt <= 8'd0;
            r_run_cnt  <= 6'd0;
            r_prev_bit <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_run_cnt  <= w_run_cnt_next;
            r_prev_bit <= QUANT_DATA_I;
        end
    end

    // Output register: live bit in RUN, otherwise the idle bit for this phase.
    always_ff @(posedge BCLK_I or posedge RESET_I) begin
        if (RESET_I) begin
            r_dsd   <= MUTE_PATTERN[7];
            r_muted <= 1'b1;
        end else begin
            r_dsd   <= (r_state == ST_RUN) ? QUANT_DATA_I : MUTE_PATTERN[3'd7 - r_phase];
            r_muted <= (r_state != ST_RUN);
        end
    end

    assign DSD_DATA_O = r_dsd;
    assign MUTED_O    = r_muted;
    assign RUNNING_O  = (r_state == ST_RUN);
    assign FAULT_O    = (r_state == ST_FAULT);
    assign STATE_O    = r_state;

endmodule

// File: tb/tb_dsm_output_sequencer.sv
// Directed bench for dsm_output_sequencer with the default parameters
// (16 arm bytes, fault after 28 identical bits, idle byte 8'h69).
module tb_dsm_output_sequencer;

  localparam logic [7:0] PAT = 8'h69;

  logic       BCLK_I = 1'b0;
  logic       RESET_I;
  logic       ENABLE_I;
  logic       CLEAR_FAULT_I;
  logic       QUANT_DATA_I;
  logic       DSD_DATA_O;
  logic       MUTED_O;
  logic       RUNNING_O;
  logic       FAULT_O;
  logic [2:0] STATE_O;

  int n_vec   = 0;
  int n_bad   = 0;
  int n_edges = 0;  // posedges since the last reset release

  dsm_output_sequencer dut (
    .BCLK_I        (BCLK_I),
    .RESET_I       (RESET_I),
    .ENABLE_I      (ENABLE_I),
    .CLEAR_FAULT_I (CLEAR_FAULT_I),
    .QUANT_DATA_I  (QUANT_DATA_I),
    .DSD_DATA_O    (DSD_DATA_O),
    .MUTED_O       (MUTED_O),
    .RUNNING_O     (RUNNING_O),
    .FAULT_O       (FAULT_O),
    .STATE_O       (STATE_O)
  );

  // clock / watchdog
  always #5 BCLK_I = ~BCLK_I;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h (edge %0d)", tag, got, exp, n_edges);
    end
  endtask

  // One clock: inputs already set at the negedge; outputs sampled at the next negedge.
  task automatic step();
    @(posedge BCLK_I);
    n_edges++;
    @(negedge BCLK_I);
  endtask

  // Idle bit expected after n edges: edge k outputs PAT[7 - ((k-1) mod 8)].
  function automatic logic idle_bit(input int n);
    logic [7:0] p;
    p = PAT;
    return p[7 - ((n - 1) % 8)];
  endfunction

  task automatic check_idle(input string tag);
    check(tag, 8'(DSD_DATA_O), 8'(idle_bit(n_edges)));
    check({tag, "_muted"}, 8'(MUTED_O), 8'd1);
  endtask

  task automatic live_bit(input logic q, input string tag);
    QUANT_DATA_I = q;
    step();
    check(tag, 8'(DSD_DATA_O), 8'(q));
    check({tag, "_muted"}, 8'(MUTED_O), 8'd0);
  endtask

  // Bounded wait for a run state; the output must stay idle meanwhile.
  task automatic wait_run(input int budget, input string tag);
    int k;
    k = 0;
    while (STATE_O !== 3'd2 && k < budget) begin
      step();
      check_idle({tag, "_idle"});
      k++;
    end
    check(tag, 8'(STATE_O), 8'd2);
  endtask

  initial begin
    int p;
    RESET_I       = 1'b1;
    ENABLE_I      = 1'b0;
    CLEAR_FAULT_I = 1'b0;
    QUANT_DATA_I  = 1'b0;
    @(negedge BCLK_I);
    check("rst_dsd", 8'(DSD_DATA_O), 8'd0);
    check("rst_muted", 8'(MUTED_O), 8'd1);
    check("rst_running", 8'(RUNNING_O), 8'd0);
    check("rst_fault", 8'(FAULT_O), 8'd0);
    check("rst_state", 8'(STATE_O), 8'd0);
    RESET_I = 1'b0;
    n_edges = 0;

    // Idle pattern 0,1,1,0,1,0,0,1 repeating while disabled.
    for (int i = 0; i < 32; i++) begin
      step();
      check_idle("mute_idle");
    end

    // Enable mid-byte (phase 3): ARM only at the next boundary (edge 40).
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("pre_en");
    end
    ENABLE_I = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle("pre_arm");
    end
    check("still_mute", 8'(STATE_O), 8'd0);
    step();
    check_idle("arm_edge");
    check("arm_entry", 8'(STATE_O), 8'd1);

    // Exactly 16 idle bytes in ARM; RUN entry at edge 168.
    for (int i = 0; i < 127; i++) begin
      step();
      check_idle("arm_idle");
    end
    check("arm_last", 8'(STATE_O), 8'd1);
    step();
    check("run_entry", 8'(STATE_O), 8'd2);
    check("run_ack", 8'(RUNNING_O), 8'd1);
    check_idle("run_entry_out");

    // Alternating data never faults.
    for (int i = 0; i < 1000; i++) begin
      live_bit(1'(i % 2), "alt_live");
    end
    check("alt_nofault", 8'(FAULT_O), 8'd0);
    check("alt_state", 8'(STATE_O), 8'd2);

    // Drop enable at phase 2: live through phase 7, idle from next phase 0.
    live_bit(1'b0, "drop_live");
    live_bit(1'b1, "drop_live");
    ENABLE_I = 1'b0;
    for (int k = 0; k < 6; k++) begin
      live_bit(1'(k % 2), "drop_tail");
    end
    check("drop_state", 8'(STATE_O), 8'd0);
    step();
    check("drop_first_msb", 8'(DSD_DATA_O), 8'd0);
    check_idle("drop_idle");
    for (int i = 0; i < 7; i++) begin
      step();
      check_idle("drop_idle");
    end

    // Re-arm, then a run of 28 ones trips the fault mid-byte.
    ENABLE_I = 1'b1;
    wait_run(300, "rearm");
    live_bit(1'b0, "pre_run");
    for (int k = 0; k < 27; k++) begin
      live_bit(1'b1, "ones");
    end
    check("ones27_fault", 8'(FAULT_O), 8'd0);
    check("ones27_state", 8'(STATE_O), 8'd2);
    live_bit(1'b1, "ones28_live");
    check("ones28_fault", 8'(FAULT_O), 8'd1);
    check("ones28_state", 8'(STATE_O), 8'd4);
    check("ones28_running", 8'(RUNNING_O), 8'd0);
    step();
    check_idle("fault_cutover");

    // FAULT ignores ENABLE_I=1 even with CLEAR_FAULT_I=1.
    CLEAR_FAULT_I = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check_idle("fault_idle");
    end
    check("fault_hold_en", 8'(STATE_O), 8'd4);

    // Drop enable: MUTE at the next boundary, not before.
    ENABLE_I = 1'b0;
    p = n_edges % 8;
    for (int k = 0; k < 7 - p; k++) begin
      step();
      check("fault_wait", 8'(STATE_O), 8'd4);
    end
    step();
    check("fault_clear", 8'(STATE_O), 8'd0);
    check("fault_clear_flag", 8'(FAULT_O), 8'd0);
    CLEAR_FAULT_I = 1'b0;

    // Reset at phase 4 in RUN aborts at once.
    ENABLE_I = 1'b1;
    wait_run(300, "rearm2");
    begin
      int k;
      k = 0;
      while (n_edges % 8 != 4 && k < 16) begin
        live_bit(1'(k % 2), "pre_rst_live");
        k++;
      end
    end
    check("pre_rst_dsd", 8'(DSD_DATA_O), 8'd1);
    RESET_I = 1'b1;
    #1;
    check("abort_dsd", 8'(DSD_DATA_O), 8'd0);
    check("abort_muted", 8'(MUTED_O), 8'd1);
    check("abort_running", 8'(RUNNING_O), 8'd0);
    check("abort_fault", 8'(FAULT_O), 8'd0);
    check("abort_state", 8'(STATE_O), 8'd0);
    @(negedge BCLK_I);
    RESET_I  = 1'b0;
    ENABLE_I = 1'b0;
    n_edges  = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_idle("post_rst_idle");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
